// File: rtl/vec_out_packer.sv
// vec_out_packer: result-vector FIFO drained as byte-masked s8/s16 store beats; define VEC_OUT_PACKER_SAT8_EN to saturate s8 lanes
module vec_out_packer #(
  parameter int VLEN      = 16,
  parameter int DEPTH     = 4,
  parameter int BUS_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [VLEN*16-1:0]           in_vec,
  input  logic                         output_req,
  input  logic                         out_16b,
  input  logic [$clog2(VLEN):0]        vec_valid_num_col,
  output logic                         req_ack,
  output logic                         output_valid,
  input  logic                         output_ready,
  output logic [BUS_WIDTH-1:0]         output_data,
  output logic [BUS_WIDTH/8-1:0]       output_mask,
  output logic                         output_last,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);
  localparam int NB = BUS_WIDTH / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(VLEN) + 1;
  localparam int SW = $clog2(2 * VLEN);
  localparam int OW = $clog2(2 * VLEN + NB) + 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [VLEN*16-1:0] mem [DEPTH];
  logic [VLEN*16-1:0] head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [OW-1:0] off, b_total, idx;
  logic [NW-1:0] ncol, ncol_in;
  logic [7:0] strm [2**SW];
  logic mode, ack, push, pop, start, fire, last;
  assign fifo_full  = count == CW'(DEPTH);
  assign fifo_empty = count == '0;
  assign fifo_count = count;
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign start      = state == IDLE && output_req && !fifo_empty;
  assign fire       = state == SEND && output_ready;
  assign pop        = fire && last;
  assign head       = mem[rd_ptr];
  assign ncol_in    = (vec_valid_num_col == '0 || vec_valid_num_col > NW'(VLEN)) ? NW'(VLEN) : vec_valid_num_col;
  assign b_total    = mode ? OW'({ncol, 1'b0}) : OW'(ncol);
  assign last       = off + OW'(NB) >= b_total;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_vec;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      off    <= '0;
      ack    <= 1'b0;
      mode   <= 1'b0;
      ncol   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
      off    <= pop ? '0 : fire ? off + OW'(NB) : off;
      ack    <= start;
      if (start) begin
        mode <= out_16b;
        ncol <= ncol_in;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (start ? SEND : IDLE) : (pop ? IDLE : SEND);
  // s16 bytes fall straight out of the little-endian lane packing; s8 uses one byte per lane
  always_comb begin
    for (int j = 0; j < 2**SW; j++) strm[j] = 8'h00;
    for (int j = 0; j < VLEN; j++)
`ifdef VEC_OUT_PACKER_SAT8_EN
      strm[j] = mode ? head[8*j +: 8] :
                $signed(head[16*j +: 16]) > 16'sd127  ? 8'h7F :
                $signed(head[16*j +: 16]) < -16'sd128 ? 8'h80 : head[16*j +: 8];
`else
      strm[j] = mode ? head[8*j +: 8] : head[16*j +: 8];
`endif
    for (int j = VLEN; j < 2 * VLEN; j++) strm[j] = head[8*j +: 8];
  end
  always_comb begin
    output_valid = state == SEND;
    req_ack      = ack;
    output_last  = output_valid && last;
    output_data  = '0;
    output_mask  = '0;
    idx          = '0;
    for (int k = 0; k < NB; k++) begin
      idx = off + OW'(k);
      if (output_valid && idx < b_total) begin
        output_data[8*k +: 8] = strm[idx[SW-1:0]];
        output_mask[k]        = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vec_out_packer.sv
// tb_vec_out_packer: randomized and directed checks of vec_out_packer against a byte-stream queue model
module tb_vec_out_packer;
  localparam int VLEN = 16, DEPTH = 4, BW = 32, NB = BW / 8;
  logic clk = 0, rst_n = 0, in_valid = 0, output_req = 0, out_16b = 0, output_ready = 0;
  logic [VLEN*16-1:0] in_vec = '0;
  logic [4:0] vec_valid_num_col = '0;
  logic in_ready, req_ack, output_valid, output_last, fifo_full, fifo_empty;
  logic [BW-1:0] output_data;
  logic [NB-1:0] output_mask;
  logic [2:0] fifo_count;
  int n_chk = 0, n_fail = 0;
  logic [VLEN*16-1:0] q[$];
  logic [VLEN*16-1:0] v;
  always #5 clk = ~clk;
  vec_out_packer #(.VLEN(VLEN), .DEPTH(DEPTH), .BUS_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .output_req(output_req), .out_16b(out_16b), .vec_valid_num_col(vec_valid_num_col),
    .req_ack(req_ack), .output_valid(output_valid), .output_ready(output_ready),
    .output_data(output_data), .output_mask(output_mask), .output_last(output_last),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] ref_byte(input logic [VLEN*16-1:0] vv, input bit m, input int j);
    logic [15:0] w;
    w = vv[16*(m ? j / 2 : j) +: 16];
    if (m) return (j % 2) ? w[15:8] : w[7:0];
`ifdef VEC_OUT_PACKER_SAT8_EN
    if ($signed(w) > 127) return 8'h7F;
    if ($signed(w) < -128) return 8'h80;
`endif
    return w[7:0];
  endfunction
  function automatic logic [VLEN*16-1:0] rand_vec();
    logic [VLEN*16-1:0] r;
    for (int i = 0; i < VLEN / 2; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction
  task automatic push_vec(input logic [VLEN*16-1:0] pv);
    in_valid = 1;
    in_vec = pv;
    check("push_ready", in_ready, 1);
    if (in_ready) begin
      step;
      q.push_back(pv);
      check("empty_after_push", fifo_empty, 0);
    end
    in_valid = 0;
  endtask
  task automatic drain(input bit m, input int nc, input int stall_at, input bit push_last, input logic [VLEN*16-1:0] pv);
    int n, b_tot, beats;
    logic [BW-1:0] ed;
    logic [NB-1:0] em;
    logic [VLEN*16-1:0] hv;
    bit full_pre;
    hv = q[0];
    n = (nc == 0 || nc > VLEN) ? VLEN : nc;
    b_tot = n * (m ? 2 : 1);
    beats = (b_tot + NB - 1) / NB;
    output_req = 1;
    out_16b = m;
    vec_valid_num_col = 5'(nc);
    step;
    check("req_ack", req_ack, 1);
    output_req = 0;
    out_16b = 1'($urandom);
    vec_valid_num_col = 5'($urandom);
    for (int b = 0; b < beats; b++) begin
      ed = '0;
      em = '0;
      for (int k = 0; k < NB; k++)
        if (b * NB + k < b_tot) begin
          ed[8*k +: 8] = ref_byte(hv, m, b * NB + k);
          em[k] = 1'b1;
        end
      if (b == stall_at) begin
        output_ready = 0;
        repeat (3) begin
          check("stall_data", output_data, ed);
          check("stall_mask", output_mask, em);
          step;
        end
      end
      check("valid", output_valid, 1);
      check("data", output_data, ed);
      check("mask", output_mask, em);
      check("last", output_last, b == beats - 1);
      output_ready = 1;
      full_pre = q.size() == DEPTH;
      if (b == beats - 1 && push_last) begin
        in_valid = 1;
        in_vec = pv;
        check("in_ready_last", in_ready, !full_pre);
      end
      step;
      output_ready = 0;
      in_valid = 0;
      if (b == beats - 1 && push_last && !full_pre) q.push_back(pv);
    end
    void'(q.pop_front());
    check("valid_drop", output_valid, 0);
    check("ack_pulse", req_ack, 0);
    check("count", fifo_count, q.size());
    check("empty", fifo_empty, q.size() == 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (2) step;
    check("rst_in_ready", in_ready, 1);
    check("rst_req_ack", req_ack, 0);
    check("rst_valid", output_valid, 0);
    check("rst_data", output_data, 0);
    check("rst_mask", output_mask, 0);
    check("rst_last", output_last, 0);
    check("rst_full", fifo_full, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_count", fifo_count, 0);
    rst_n = 1;
    step;
    output_req = 1;
    step;
    check("req_empty_ack", req_ack, 0);
    check("req_empty_valid", output_valid, 0);
    output_req = 0;
    for (int i = 0; i < VLEN; i++) v[16*i +: 16] = 16'(i);
    push_vec(v);
    drain(0, 16, -1, 0, '0);
    push_vec(v);
    drain(0, 5, -1, 0, '0);
    v = '0;
    v[47:0] = 48'h3333_2222_1111;
    push_vec(v);
    drain(1, 3, 1, 0, '0);
    for (int i = 0; i < DEPTH; i++) push_vec(rand_vec());
    check("full", fifo_full, 1);
    check("full_in_ready", in_ready, 0);
    in_valid = 1;
    in_vec = rand_vec();
    step;
    in_valid = 0;
    check("full_count", fifo_count, DEPTH);
    drain(0, 16, -1, 1, rand_vec());
    check("after_pop_ready", in_ready, 1);
    while (q.size() > 0) drain(1, 0, 2, 0, '0);
    v = '0;
    v[31:0] = 32'hFF00_0190;
    push_vec(v);
    output_req = 1;
    vec_valid_num_col = 5'd2;
    out_16b = 0;
    step;
    output_req = 0;
    check("sat_ack", req_ack, 1);
`ifdef VEC_OUT_PACKER_SAT8_EN
    check("sat_data", output_data, 32'h0000_807F);
`else
    check("sat_data", output_data, 32'h0000_0090);
`endif
    check("sat_mask", output_mask, 4'h3);
    output_ready = 1;
    step;
    output_ready = 0;
    void'(q.pop_front());
    check("sat_done", output_valid, 0);
    for (int it = 0; it < 60; it++) begin
      if (q.size() < DEPTH && ($urandom_range(0, 1) == 0 || q.size() == 0)) push_vec(rand_vec());
      else drain(1'($urandom), $urandom_range(0, 20), $urandom_range(0, 5) - 1, 1'($urandom), rand_vec());
    end
    if (q.size() == 0) push_vec(rand_vec());
    output_req = 1;
    out_16b = 1;
    vec_valid_num_col = 5'd16;
    step;
    output_req = 0;
    rst_n = 0;
    #1;
    check("mid_rst_valid", output_valid, 0);
    check("mid_rst_data", output_data, 0);
    check("mid_rst_empty", fifo_empty, 1);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    q.delete();
    step;
    rst_n = 1;
    step;
    push_vec(rand_vec());
    drain(0, 7, 0, 0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
